// File: rtl/muldiv_hilo_unit.sv
// rtl/muldiv_hilo_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
module muldiv_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] Rdata1,
  input  logic [WIDTH-1:0] Rdata2,
  input  logic             WrHi,
  input  logic             WrLo,
  input  logic [WIDTH-1:0] Wdata,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  // Latched operation context. opnd is the multiplicand (multiply) or the
  // divisor (divide); acc_lo starts as the multiplier or the dividend and
  // shifts into the low product half or the quotient.
  logic [1:0]       op_q;
  logic             sign_a;
  logic             sign_b;
  logic             div_zero;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  // Operand magnitudes presented at Start; MULTU/DIVU (Op[0]=1) are unsigned.
  logic             in_signed;
  logic             in_sa;
  logic             in_sb;
  logic [WIDTH-1:0] in_maga;
  logic [WIDTH-1:0] in_magb;

  // Per-iteration next values and the sign-corrected final values.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_diff;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Start-time sign extraction and absolute values.
  always_comb begin
    in_signed = ~Op[0];
    in_sa     = in_signed & Rdata1[WIDTH-1];
    in_sb     = in_signed & Rdata2[WIDTH-1];
    in_maga   = in_sa ? -Rdata1 : Rdata1;
    in_magb   = in_sb ? -Rdata2 : Rdata2;
  end

  // One shift-add multiply step or one restoring divide step per cycle.
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    div_diff = {1'b0, acc_hi, acc_lo[WIDTH-1]} - {2'b00, opnd};
    step_hi  = acc_hi;
    step_lo  = acc_lo;
    if (op_q[1]) begin
      if (!div_diff[WIDTH+1]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
        step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Sign correction. A zero divisor forces an all-ones quotient; the
  // remainder path already reproduces the original dividend in that case.
  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = (~op_q[0] & (sign_a ^ sign_b)) ? -prod : prod;
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (op_q[1]) begin
      fix_hi = (~op_q[0] & sign_a) ? -acc_hi : acc_hi;
      if (div_zero) begin
        fix_lo = {WIDTH{1'b1}};
      end else begin
        fix_lo = (~op_q[0] & (sign_a ^ sign_b)) ? -acc_lo : acc_lo;
      end
    end
  end

  // Control FSM, iteration datapath and the architectural HI/LO registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      op_q     <= 2'b00;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      opnd     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            state    <= S_CALC;
            busy_q   <= 1'b1;
            cnt      <= '0;
            op_q     <= Op;
            sign_a   <= in_sa;
            sign_b   <= in_sb;
            div_zero <= ~|Rdata2;
            opnd     <= Op[1] ? in_magb : in_maga;
            acc_lo   <= Op[1] ? in_maga : in_magb;
            acc_hi   <= '0;
          end else begin
            if (WrHi) hi_q <= Wdata;
            if (WrLo) lo_q <= Wdata;
          end
        end
        S_CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) state <= S_FIX;
        end
        S_FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb/tb_muldiv_hilo_unit.sv - directed self-checking bench for muldiv_hilo_unit
module tb_muldiv_hilo_unit;

  logic        CLK;
  logic        RST;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] Rdata1;
  logic [31:0] Rdata2;
  logic        WrHi;
  logic        WrLo;
  logic [31:0] Wdata;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int checks = 0;
  int errors = 0;

  muldiv_hilo_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Op(Op),
    .Rdata1(Rdata1), .Rdata2(Rdata2),
    .WrHi(WrHi), .WrLo(WrLo), .Wdata(Wdata),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Waits for Done, sampling 1ns after each edge; lat counts edges after
  // the accepting edge, bcnt counts samples with Busy high (incl. after E0).
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = Busy ? 1 : 0;
    while (!Done && lat < 100) begin
      @(posedge CLK); #1;
      lat++;
      if (Busy) bcnt++;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcnt);
    @(negedge CLK);
    Start = 1'b1; Op = op; Rdata1 = a; Rdata2 = b;
    @(posedge CLK); #1;
    Start = 1'b0;
    wait_done(lat, bcnt);
  endtask

  task automatic test_reset();
    int k;
    checks++; if ({Hi, Lo, Busy, Done} !== 66'd0) begin errors++;
      $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b want zeros", Hi, Lo, Busy, Done); end
    @(negedge CLK); WrHi = 1'b1; WrLo = 1'b1; Wdata = 32'hAAAA5555;
    @(negedge CLK); WrHi = 1'b0; WrLo = 1'b0;
    checks++; if (Lo !== 32'hAAAA5555) begin errors++;
      $display("FAIL mt_both: got lo=%h want aaaa5555", Lo); end
    Start = 1'b1; Op = 2'b01; Rdata1 = 32'd3; Rdata2 = 32'd3;
    @(negedge CLK); Start = 1'b0;
    repeat (5) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    checks++; if ({Hi, Lo, Busy, Done} !== 66'd0) begin errors++;
      $display("FAIL reset_midrun: got hi=%h lo=%h busy=%b done=%b want zeros", Hi, Lo, Busy, Done); end
    @(negedge CLK); RST = 1'b1;
    k = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (Busy || Done || Lo !== 32'd0) k++;
    end
    checks++; if (k !== 0) begin errors++;
      $display("FAIL reset_abort: got %0d active cycles want 0", k); end
    @(negedge CLK); WrHi = 1'b1; Wdata = 32'h12345678;
    @(posedge CLK); #1;
    WrHi = 1'b0;
    checks++; if (Hi !== 32'h12345678) begin errors++;
      $display("FAIL mthi_hi: got %h want 12345678", Hi); end
    checks++; if (Lo !== 32'd0) begin errors++;
      $display("FAIL mthi_lo: got %h want 00000000", Lo); end
    checks++; if (Done !== 1'b0) begin errors++;
      $display("FAIL mthi_done: got %b want 0", Done); end
  endtask

  task automatic test_mult();
    int lat, bcnt;
    run_op(2'b00, 32'hFFFFFFFD, 32'd5, lat, bcnt);
    checks++; if (lat !== 33) begin errors++;
      $display("FAIL mult_latency: got %0d want 33", lat); end
    checks++; if (bcnt !== 33) begin errors++;
      $display("FAIL mult_busy_cycles: got %0d want 33", bcnt); end
    checks++; if (Hi !== 32'hFFFFFFFF || Lo !== 32'hFFFFFFF1) begin errors++;
      $display("FAIL mult_neg: got %h_%h want ffffffff_fffffff1", Hi, Lo); end
    @(posedge CLK); #1;
    checks++; if (Done !== 1'b0) begin errors++;
      $display("FAIL done_one_cycle: got %b want 0", Done); end
  endtask

  task automatic test_multu();
    int lat, bcnt;
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcnt);
    checks++; if (Hi !== 32'hFFFFFFFE || Lo !== 32'h00000001) begin errors++;
      $display("FAIL multu_max: got %h_%h want fffffffe_00000001", Hi, Lo); end
  endtask

  task automatic test_div();
    int lat, bcnt;
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, lat, bcnt);
    checks++; if (Lo !== 32'hFFFFFFFD || Hi !== 32'hFFFFFFFF) begin errors++;
      $display("FAIL div_neg: got lo=%h hi=%h want fffffffd ffffffff", Lo, Hi); end
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, bcnt);
    checks++; if (Lo !== 32'h80000000 || Hi !== 32'h00000000) begin errors++;
      $display("FAIL div_minint: got lo=%h hi=%h want 80000000 00000000", Lo, Hi); end
    run_op(2'b11, 32'd100, 32'd7, lat, bcnt);
    checks++; if (Lo !== 32'd14 || Hi !== 32'd2) begin errors++;
      $display("FAIL divu_basic: got lo=%h hi=%h want 0000000e 00000002", Lo, Hi); end
  endtask

  task automatic test_divzero();
    int lat, bcnt;
    run_op(2'b11, 32'd7, 32'd0, lat, bcnt);
    checks++; if (lat !== 33) begin errors++;
      $display("FAIL divz_latency: got %0d want 33", lat); end
    checks++; if (Lo !== 32'hFFFFFFFF || Hi !== 32'h00000007) begin errors++;
      $display("FAIL divu_zero: got lo=%h hi=%h want ffffffff 00000007", Lo, Hi); end
  endtask

  task automatic test_busy_ignore();
    int lat, bcnt;
    @(negedge CLK);
    Start = 1'b1; Op = 2'b01; Rdata1 = 32'd6; Rdata2 = 32'd7;
    @(posedge CLK); #1;
    Start = 1'b0;
    repeat (4) @(negedge CLK);
    Start = 1'b1; Op = 2'b10; Rdata1 = 32'd100; Rdata2 = 32'd3;
    WrHi = 1'b1; WrLo = 1'b1; Wdata = 32'h0000FFFF;
    repeat (3) @(negedge CLK);
    Start = 1'b0; WrHi = 1'b0; WrLo = 1'b0;
    checks++; if (Hi !== 32'h00000007 || Lo !== 32'hFFFFFFFF) begin errors++;
      $display("FAIL hold_in_busy: got %h_%h want 00000007_ffffffff", Hi, Lo); end
    wait_done(lat, bcnt);
    checks++; if (Hi !== 32'd0 || Lo !== 32'd42) begin errors++;
      $display("FAIL busy_ignore: got hi=%h lo=%h want 00000000 0000002a", Hi, Lo); end
    @(posedge CLK); #1;
    checks++; if (Busy !== 1'b0) begin errors++;
      $display("FAIL no_second_op: got busy=%b want 0", Busy); end
  endtask

  task automatic test_start_vs_mt();
    int lat, bcnt;
    @(negedge CLK);
    Start = 1'b1; Op = 2'b01; Rdata1 = 32'd2; Rdata2 = 32'd3;
    WrLo = 1'b1; Wdata = 32'hDEADBEEF;
    @(posedge CLK); #1;
    Start = 1'b0; WrLo = 1'b0;
    checks++; if (Lo === 32'hDEADBEEF) begin errors++;
      $display("FAIL start_wins_early: got lo=%h want not deadbeef", Lo); end
    wait_done(lat, bcnt);
    checks++; if (Hi !== 32'd0 || Lo !== 32'd6) begin errors++;
      $display("FAIL start_wins: got hi=%h lo=%h want 00000000 00000006", Hi, Lo); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    run_op(2'b01, 32'd10, 32'd10, lat, bcnt);
    checks++; if (Lo !== 32'd100 || Hi !== 32'd0) begin errors++;
      $display("FAIL b2b_first: got hi=%h lo=%h want 00000000 00000064", Hi, Lo); end
    run_op(2'b11, 32'd100, 32'd7, lat, bcnt);
    checks++; if (lat !== 33) begin errors++;
      $display("FAIL b2b_latency: got %0d want 33", lat); end
    checks++; if (Lo !== 32'd14 || Hi !== 32'd2) begin errors++;
      $display("FAIL b2b_second: got lo=%h hi=%h want 0000000e 00000002", Lo, Hi); end
  endtask

  initial begin
    RST = 1'b0; Start = 1'b0; Op = 2'b00; Rdata1 = '0; Rdata2 = '0;
    WrHi = 1'b0; WrLo = 1'b0; Wdata = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK); RST = 1'b1;
    #1;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_divzero();
    test_busy_ignore();
    test_start_vs_mt();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Multi-cycle multiply/divide responder for the MIPS EX stage.
- Owns the architectural HI/LO registers.
- EX is the initiator: it issues MULT/MULTU/DIV/DIVU with a Start pulse, writes HI/LO directly for MTHI/MTLO, and reads HI/LO for MFHI/MFLO.
- Provides a Busy/Done handshake so the pipeline can stall on HI/LO consumers.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits, and the iteration count is WIDTH.

Ports:
- CLK  input  1  clock, rising-edge.
- RST  input  1  asynchronous reset, active-low.
- Start  input  1  request pulse; sampled only in IDLE.
- Op  input  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- Rdata1  input  WIDTH  rs operand (multiplicand / dividend).
- Rdata2  input  WIDTH  rt operand (multiplier / divisor).
- WrHi  input  1  MTHI write enable.
- WrLo  input  1  MTLO write enable.
- Wdata  input  WIDTH  MTHI/MTLO data.
- Busy  output  1  high while an operation is in flight.
- Done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- Hi  output  WIDTH  HI register, driven directly from the flop.
- Lo  output  WIDTH  LO register, driven directly from the flop.

Behaviour:
- Reset (RST=0, async): state=IDLE, Hi=0, Lo=0, Busy=0, Done=0, iteration counter=0. Reset mid-operation aborts the operation; no partial result is written.
- States:
  - IDLE -> CALC when Start=1.
  - CALC runs WIDTH cycles, then -> FIX.
  - FIX -> IDLE.
- Busy = (state != IDLE), registered.
- Done is registered and high for exactly the one cycle after the FIX edge.
- Start acceptance, at edge E0 in IDLE with Start=1:
  - Latch Op.
  - Latch operand magnitudes (two's-complement absolute value for signed ops) and the sign bits.
  - Clear the accumulator; counter=0.
- CALC, one iteration per cycle:
  - Multiply: shift-add, one multiplier bit per cycle, 2*WIDTH-bit unsigned product.
  - Divide: restoring, one quotient bit per cycle, WIDTH-bit quotient and remainder.
- FIX (edge E(WIDTH+1)): apply sign correction, then write Hi/Lo at that edge.
- Timing: Busy is high from E0 through E(WIDTH+1). Done is high between E(WIDTH+1) and E(WIDTH+2). Total latency is WIDTH+1 edges from Start to Hi/Lo valid (33 for WIDTH=32).
- Multiply results:
  - Hi = product[2W-1:W], Lo = product[W-1:0].
  - MULT: product is negated iff the operand signs differ.
- Divide results:
  - Lo = quotient, Hi = remainder.
  - DIV: quotient negated iff signs differ; remainder takes the sign of the dividend (truncation toward zero).
- Divide by zero (DIV or DIVU): Lo = all ones, Hi = Rdata1 as latched. Same latency, no exception.
- DIV 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0. No trap.
- Hi/Lo hold their old values throughout Busy. They are written only at FIX, or by MT writes.
- MT writes:
  - In IDLE with Start=0: WrHi loads Hi<=Wdata and WrLo loads Lo<=Wdata on the next edge. Both may assert in the same cycle. Done is not pulsed.
- Conflicts:
  - Start and WrHi/WrLo in the same IDLE cycle: Start wins and the MT writes are dropped.
  - Start, WrHi or WrLo while Busy=1: ignored. EX must stall.
- Back-to-back: Start is accepted in the Done cycle (state is IDLE), giving a new operation with no gap.
- Arithmetic is modulo 2^WIDTH; there are no overflow flags.

Test Plan:
- Reset then idle: RST low mid-run -> Hi=0, Lo=0, Busy=0, Done=0. After release, MTHI 0x12345678 -> Hi=0x12345678 next edge, Lo=0, no Done.
- MULT Rdata1=0xFFFFFFFD (-3), Rdata2=5 -> Done 33 edges after Start; Hi=0xFFFFFFFF, Lo=0xFFFFFFF1; Busy high for exactly 33 cycles.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
- DIV 0xFFFFFFF9 (-7) / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU 7 / 0 -> Lo=0xFFFFFFFF, Hi=0x00000007, normal latency.
- Conflicts:
  - Start plus WrLo in the same idle cycle: MULTU 2x3 gives Hi=0, Lo=6; the WrLo is lost.
  - Start and MTHI issued mid-Busy: ignored; the final Hi/Lo match the first operation only.
  - A second Start in the Done cycle is accepted.
